// File: rtl/sdio_uart_pkg.sv
// Shared definitions for the command-frame UART transmitter.
// Holds the TX FSM state encoding, the default header/trailer bytes, the
// default long-command mask, the queue entry layout/width and the maximum
// frame length, plus the helper that classifies a command as long or short.
package sdio_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } tx_state_t;

    localparam logic [7:0]  HDR_DEFAULT       = 8'hF0;
    localparam logic [7:0]  TRL_DEFAULT       = 8'hFF;
    // Command indices 17, 18, 24 and 25 are long by default.
    localparam logic [63:0] LONG_MASK_DEFAULT = 64'h0000_0000_0306_0000;

    localparam int ENTRY_W   = 40;
    localparam int MAX_FRAME = 7;
    localparam int IDX_W     = 3;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] arg;
    } cmd_entry_t;

    // Long commands live in the 0..63 index space (cmd[7:6] == 0) and are
    // selected individually by the mask.
    function automatic logic cmd_is_long(input logic [7:0]  cmd,
                                         input logic [63:0] mask);
        return (cmd[7:6] == 2'b00) && mask[cmd[5:0]];
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command queue, DEPTH entries of WIDTH bits.
// Ports:
//   clk, rst      - clock, synchronous active-high reset (pointers/count only)
//   push, wr_data - write request and data; ignored while full
//   pop           - read request; ignored while empty
//   rd_data       - head entry (combinational read of the head slot)
//   level         - occupancy, 0..DEPTH
//   full, empty   - occupancy flags
module cmd_fifo
    import sdio_uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // Fullness is judged before the edge, so a push into a full queue is
    // refused even when a pop happens on the same edge.
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    // Pointers are exactly AW bits wide, so DEPTH being a power of two makes
    // them wrap modulo DEPTH for free.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/cmd_frame_tx.sv
// Command-to-UART framer. Each falling edge of finsh_i queues the current
// {cmd_dat_i, arg_i}; queued commands are sent one byte per UART write
// strobe, either as the bare command byte (short) or as
// HDR, cmd, ARG_BYTES argument bytes MSB first, TRL (long).
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   finsh_i     - command-complete flag; high->low marks a new command
//   cmd_dat_i   - command byte, arg_i - 32-bit argument
//   txfull      - UART TX FIFO full; holds the current byte back
//   txen, dat_o - one-cycle write strobe and its byte (dat_o holds otherwise)
//   busy_o      - frame in progress or queue non-empty
//   level_o     - queue occupancy
//   overflow_o  - sticky drop flag, cleared by clr_ovf_i (a drop wins)
module cmd_frame_tx
    import sdio_uart_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          ARG_BYTES = 4,
    parameter logic [7:0]  HDR       = HDR_DEFAULT,
    parameter logic [7:0]  TRL       = TRL_DEFAULT,
    parameter logic [63:0] LONG_MASK = LONG_MASK_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   finsh_i,
    input  logic [7:0]             cmd_dat_i,
    input  logic [31:0]            arg_i,
    input  logic                   txfull,
    output logic                   txen,
    output logic [7:0]             dat_o,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   overflow_o,
    input  logic                   clr_ovf_i
);

    logic       finsh_p1;
    logic       cmd_evt;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    cmd_entry_t wr_entry;
    cmd_entry_t head;

    tx_state_t        state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] len_q, len_d;
    logic [7:0]       frame_q [8];
    logic [7:0]       frame_d [8];
    logic             txen_d;
    logic [7:0]       dat_d;
    logic [31:0]      arg_sh;

    // ---- Stage: command capture (finsh_i falling edge) ----
    assign cmd_evt  = finsh_p1 && !finsh_i;
    assign wr_entry = '{cmd: cmd_dat_i, arg: arg_i};

    always_ff @(posedge clk) begin
        if (rst) finsh_p1 <= 1'b0;
        else     finsh_p1 <= finsh_i;
    end

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (cmd_evt),
        .wr_data (wr_entry),
        .pop     (fifo_pop),
        .rd_data (head),
        .level   (level_o),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst)                        overflow_o <= 1'b0;
        else if (cmd_evt && fifo_full)  overflow_o <= 1'b1;
        else if (clr_ovf_i)             overflow_o <= 1'b0;
    end

    // ---- Stage: frame build and byte sequencing ----
    // Left-justify the used argument bytes so byte i of the argument field
    // is always arg_sh[31-8i -: 8] regardless of ARG_BYTES.
    assign arg_sh = head.arg << (8 * (4 - ARG_BYTES));

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        frame_d  = frame_q;
        txen_d   = 1'b0;
        dat_d    = dat_o;
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                fifo_pop = 1'b1;
                idx_d    = '0;
                if (cmd_is_long(head.cmd, LONG_MASK)) begin
                    frame_d[0] = HDR;
                    frame_d[1] = head.cmd;
                    for (int i = 0; i < 4; i++) begin
                        if (i < ARG_BYTES) frame_d[2+i] = arg_sh[31-8*i -: 8];
                    end
                    frame_d[ARG_BYTES+2] = TRL;
                    len_d = IDX_W'(ARG_BYTES + 3);
                end else begin
                    frame_d[0] = head.cmd;
                    len_d      = IDX_W'(1);
                end
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!txfull) begin
                    txen_d  = 1'b1;
                    dat_d   = frame_q[idx_q];
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                // Mandatory low cycle after every strobe keeps txen from
                // ever being high on consecutive cycles.
                idx_d = idx_q + 3'd1;
                if (idx_q == len_q - 3'd1) state_d = ST_IDLE;
                else                       state_d = ST_SEND;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- Stage: registered UART write interface ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            txen    <= 1'b0;
            dat_o   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            txen    <= txen_d;
            dat_o   <= dat_d;
        end
    end

    always_ff @(posedge clk) begin
        frame_q <= frame_d;
    end

    assign busy_o = !rst && ((state_q != ST_IDLE) || !fifo_empty);

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Directed bench for cmd_frame_tx: one default instance (DEPTH=4,
// ARG_BYTES=4) and one ARG_BYTES=2 instance with its own command inputs.
module tb_cmd_frame_tx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, txfull, clr_ovf_i;
    logic        finsh_i, finsh2;
    logic [7:0]  cmd_dat_i, cmd2;
    logic [31:0] arg_i, arg2;
    logic        txen, txen2, busy_o, busy2, overflow_o, ovf2;
    logic [7:0]  dat_o, dat2;
    logic [2:0]  level_o, level2;

    cmd_frame_tx dut (
        .clk(clk), .rst(rst), .finsh_i(finsh_i), .cmd_dat_i(cmd_dat_i),
        .arg_i(arg_i), .txfull(txfull), .txen(txen), .dat_o(dat_o),
        .busy_o(busy_o), .level_o(level_o), .overflow_o(overflow_o),
        .clr_ovf_i(clr_ovf_i)
    );

    cmd_frame_tx #(.ARG_BYTES(2)) dut2 (
        .clk(clk), .rst(rst), .finsh_i(finsh2), .cmd_dat_i(cmd2),
        .arg_i(arg2), .txfull(txfull), .txen(txen2), .dat_o(dat2),
        .busy_o(busy2), .level_o(level2), .overflow_o(ovf2),
        .clr_ovf_i(clr_ovf_i)
    );

    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         cons = 0;
    logic       prev_txen = 1'b0;
    logic       prev_txen2 = 1'b0;
    logic [7:0] bq[$];
    int         tq[$];
    logic [7:0] bq2[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe capture on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (txen === 1'b1) begin
            bq.push_back(dat_o);
            tq.push_back(cyc);
        end
        if (txen2 === 1'b1) bq2.push_back(dat2);
        if (txen === 1'b1 && prev_txen === 1'b1)   cons++;
        if (txen2 === 1'b1 && prev_txen2 === 1'b1) cons++;
        prev_txen  = txen;
        prev_txen2 = txen2;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns the cycle stamp of the push edge.
    task automatic send(input logic [7:0] c, input logic [31:0] a,
                        input logic clr, output int pc);
        cmd_dat_i = c;
        arg_i     = a;
        finsh_i   = 1'b1;
        tick();
        finsh_i   = 1'b0;
        clr_ovf_i = clr;
        tick();
        pc        = cyc;
        clr_ovf_i = 1'b0;
    endtask

    task automatic wait_n(input int n, input int budget, input string tag);
        int k = 0;
        while (bq.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(bq.size() >= n), 32'd1);
    endtask

    task automatic clear_q;
        bq.delete();
        tq.delete();
    endtask

    initial begin
        int         pc;
        logic [7:0] exp_l [7];
        logic [7:0] exp_b [7];
        logic [7:0] exp_s [5];

        rst = 1'b1; finsh_i = 1'b1; txfull = 1'b0; clr_ovf_i = 1'b0;
        cmd_dat_i = 8'h00; arg_i = 32'h0;
        finsh2 = 1'b0; cmd2 = 8'h00; arg2 = 32'h0;
        repeat (3) tick();

        chk("rst_txen",  32'(txen),       32'd0);
        chk("rst_dat",   32'(dat_o),      32'h00);
        chk("rst_busy",  32'(busy_o),     32'd0);
        chk("rst_level", 32'(level_o),    32'd0);
        chk("rst_ovf",   32'(overflow_o), 32'd0);

        // finsh_i was high through reset and drops with the release.
        rst = 1'b0; finsh_i = 1'b0;
        repeat (10) tick();
        chk("rel_no_evt_level", 32'(level_o), 32'd0);
        chk("rel_no_evt_bytes", 32'(bq.size()), 32'd0);

        // Short command
        send(8'h0D, 32'h0, 1'b0, pc);
        chk("short_level", 32'(level_o), 32'd1);
        chk("short_busy",  32'(busy_o),  32'd1);
        wait_n(1, 20, "short_timeout");
        chk("short_byte",    32'(bq[0]),      32'h0D);
        chk("short_latency", 32'(tq[0] - pc), 32'd3);
        repeat (10) tick();
        chk("short_count", 32'(bq.size()), 32'd1);
        chk("short_idle",  32'(busy_o),    32'd0);
        chk("short_hold",  32'(dat_o),     32'h0D);
        clear_q();

        // Long command 25
        exp_l = '{8'hF0, 8'h19, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF};
        send(8'h19, 32'h12345678, 1'b0, pc);
        wait_n(7, 40, "long_timeout");
        for (int i = 0; i < 7; i++) chk($sformatf("long_b%0d", i), 32'(bq[i]), 32'(exp_l[i]));
        chk("long_latency", 32'(tq[0] - pc), 32'd3);
        for (int i = 1; i < 7; i++) chk($sformatf("long_gap%0d", i), 32'(tq[i] - tq[i-1]), 32'd2);
        repeat (10) tick();
        chk("long_count", 32'(bq.size()), 32'd7);
        clear_q();

        // Backpressure mid-frame
        exp_b = '{8'hF0, 8'h11, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFF};
        send(8'h11, 32'hDEADBEEF, 1'b0, pc);
        wait_n(3, 30, "bp_pre_timeout");
        txfull = 1'b1;
        repeat (10) tick();
        chk("bp_stalled", 32'(bq.size()), 32'd3);
        txfull = 1'b0;
        wait_n(7, 40, "bp_post_timeout");
        for (int i = 0; i < 7; i++) chk($sformatf("bp_b%0d", i), 32'(bq[i]), 32'(exp_b[i]));
        repeat (10) tick();
        chk("bp_count", 32'(bq.size()), 32'd7);
        clear_q();

        // Overflow: command 1 is taken into the transmitter (which then sits
        // in backpressure), 2..5 fill the queue, 6 is dropped.
        txfull = 1'b1;
        for (int i = 1; i <= 6; i++) send(8'(i), 32'h0, 1'b0, pc);
        chk("ovf_level", 32'(level_o),    32'd4);
        chk("ovf_flag",  32'(overflow_o), 32'd1);
        clr_ovf_i = 1'b1;
        tick();
        clr_ovf_i = 1'b0;
        chk("ovf_clear", 32'(overflow_o), 32'd0);
        // Drop and clear on the same edge: the drop wins.
        send(8'h07, 32'h0, 1'b1, pc);
        chk("ovf_set_wins",    32'(overflow_o), 32'd1);
        chk("ovf_level_still", 32'(level_o),    32'd4);
        chk("ovf_no_tx",       32'(bq.size()),  32'd0);
        txfull = 1'b0;
        wait_n(5, 60, "ovf_drain_timeout");
        repeat (10) tick();
        chk("ovf_sent_count", 32'(bq.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("ovf_b%0d", i), 32'(bq[i]), 32'(i + 1));
        chk("ovf_drained", 32'(level_o), 32'd0);
        chk("ovf_idle",    32'(busy_o),  32'd0);
        clear_q();

        // Reset in the middle of a long frame with another command queued.
        send(8'h18, 32'hCAFEF00D, 1'b0, pc);
        send(8'h0D, 32'h0, 1'b0, pc);
        wait_n(3, 30, "mid_rst_timeout");
        rst = 1'b1;
        tick();
        chk("mid_rst_txen",  32'(txen),    32'd0);
        chk("mid_rst_level", 32'(level_o), 32'd0);
        chk("mid_rst_busy",  32'(busy_o),  32'd0);
        tick();
        rst = 1'b0;
        repeat (30) tick();
        chk("mid_rst_no_more", 32'(bq.size()), 32'd3);
        chk("mid_rst_level_after", 32'(level_o), 32'd0);
        clear_q();

        // ARG_BYTES=2 instance
        exp_s = '{8'hF0, 8'h12, 8'hCC, 8'hDD, 8'hFF};
        cmd2 = 8'h12; arg2 = 32'hAABBCCDD; finsh2 = 1'b1;
        tick();
        finsh2 = 1'b0;
        begin
            int k = 0;
            while (bq2.size() < 5 && k < 40) begin
                tick();
                k++;
            end
        end
        repeat (10) tick();
        chk("ab2_count", 32'(bq2.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("ab2_b%0d", i), 32'(bq2[i]), 32'(exp_s[i]));

        chk("no_back_to_back", 32'(cons), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
